// File: rtl/tt_loopback_checker.sv
// tt_loopback_checker: drives a programmable pattern onto the user-input pads and checks the looped-back pads.
// Optional build macro TT_LBCHK_OEB_STRICT_EN: a non-driving bidirectional pad also fails the vector.
module tt_loopback_checker #(
    parameter int N_I   = 10,
    parameter int N_O   = 8,
    parameter int N_IO  = 8,
    parameter int LAT   = 2,
    parameter int N_VEC = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [N_I-1:0]   stim_o,
    input  logic [N_O-1:0]   obs_out,
    input  logic [N_IO-1:0]  obs_io,
    input  logic [N_IO-1:0]  obs_oeb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      first_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0]    LAST_K    = 16'(N_VEC - 1);
    localparam logic [15:0]    NO_ERR    = 16'(N_VEC);
    localparam logic [15:0]    LFSR_SEED = 16'hACE1;
    localparam logic [15:0]    LFSR_TAPS = 16'hB400;
    localparam logic [N_I-1:0] WALK_INIT = N_I'(1);

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [N_I-1:0] pattern(input logic [1:0] m, input logic [N_I-1:0] w,
                                               input logic [15:0] l, input logic odd);
        case (m)
            2'd0:    return w;
            2'd1:    return ~w;
            2'd2:    return l[N_I-1:0];
            default: return {N_I{odd}};
        endcase
    endfunction

    state_t         state;
    logic [1:0]     mode_r;
    logic [15:0]    k;
    logic [N_I-1:0] walk;
    logic [15:0]    lfsr;

    logic [15:0]    k_nxt;
    logic [N_I-1:0] walk_nxt;
    logic [15:0]    lfsr_nxt;
    logic [N_I-1:0] stim_nxt;

    logic [N_I-1:0] pipe_stim [LAT];
    logic [15:0]    pipe_idx  [LAT];
    logic           pipe_vld  [LAT];

    logic [N_I-1:0]  chk_stim;
    logic [N_IO-1:0] exp_io;
    logic            pipe_any;
    logic            mismatch;
    logic            vec_err;

    // The walking bit is kept as a rotating one-hot so no modulo hardware is needed.
    assign k_nxt    = k + 16'd1;
    assign walk_nxt = (walk << 1) | (walk >> (N_I - 1));
    assign lfsr_nxt = lfsr_step(lfsr);
    assign stim_nxt = pattern(mode_r, walk_nxt, lfsr_nxt, k_nxt[0]);
    assign chk_stim = pipe_stim[LAT-1];
    assign vec_err  = pipe_vld[LAT-1] && mismatch;

    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            pipe_any = pipe_any | pipe_vld[i];
        end
        exp_io = '0;
        for (int i = 0; i < N_IO; i++) begin
            exp_io[i] = chk_stim[i % N_I];
        end
        mismatch = (obs_out != chk_stim[N_O-1:0]) ||
                   (((obs_io ^ exp_io) & ~obs_oeb) != '0);
`ifdef TT_LBCHK_OEB_STRICT_EN
        if (obs_oeb != '0) begin
            mismatch = 1'b1;
        end
`endif
    end

    // Each presented vector travels LAT stages to meet its looped-back response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_stim[i] <= '0;
                pipe_idx[i]  <= '0;
                pipe_vld[i]  <= 1'b0;
            end
        end else begin
            pipe_stim[0] <= stim_o;
            pipe_idx[0]  <= k;
            pipe_vld[0]  <= (state == RUN);
            for (int i = 1; i < LAT; i++) begin
                pipe_stim[i] <= pipe_stim[i-1];
                pipe_idx[i]  <= pipe_idx[i-1];
                pipe_vld[i]  <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_r    <= 2'd0;
            k         <= '0;
            walk      <= '0;
            lfsr      <= '0;
            stim_o    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_err <= NO_ERR;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        k         <= '0;
                        walk      <= WALK_INIT;
                        lfsr      <= LFSR_SEED;
                        stim_o    <= pattern(mode, WALK_INIT, LFSR_SEED, 1'b0);
                        err_cnt   <= '0;
                        pass      <= 1'b0;
                        first_err <= NO_ERR;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (k == LAST_K) begin
                        stim_o <= '0;
                        state  <= DRAIN;
                    end else begin
                        k      <= k_nxt;
                        walk   <= walk_nxt;
                        lfsr   <= lfsr_nxt;
                        stim_o <= stim_nxt;
                    end
                end
                DRAIN: begin
                    if (!pipe_any) begin
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Comparisons only occur while vectors are in flight, never in IDLE.
            if (vec_err && state != IDLE) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (first_err == NO_ERR) begin
                    first_err <= pipe_idx[LAT-1];
                end
            end
        end
    end

endmodule

// File: doc/tt_loopback_checker.md
Name: tt_loopback_checker

Overview:
- Parametrised, synthesizable successor to the pad-loopback connectivity harness used around tt_top.
- Drives a programmable stimulus pattern onto the user-input pads.
- Compares the dedicated-output and bidirectional-output pads against the stimulus after a fixed loopback latency.
- Reports a pass flag, the mismatching-vector count and the index of the first failing vector; used both in simulation benches and in on-chip self-test.

Parameters:
- N_I, 10, user input pad count (1..16).
- N_O, 8, dedicated output pad count (1..N_I).
- N_IO, 8, bidirectional pad count (1..16).
- LAT, 2, expected loopback latency in clk cycles (1..7).
- N_VEC, 64, vectors issued per run (2..65535).
- CNT_W, 16, width of error counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle run request; honoured only when busy=0.
- mode, input, 2, pattern: 0 walking-one, 1 walking-zero, 2 LFSR, 3 alternate all-0/all-1; sampled on accepted start.
- stim_o, output, N_I, stimulus to user input pads.
- obs_out, input, N_O, observed dedicated outputs.
- obs_io, input, N_IO, observed bidirectional outputs.
- obs_oeb, input, N_IO, observed bidirectional output-enable-bar (0 = driving).
- busy, output, 1, run in progress.
- done, output, 1, one-cycle pulse at end of run.
- pass, output, 1, high after a run with err_cnt==0; cleared on start.
- err_cnt, output, CNT_W, count of mismatching vectors, saturating.
- first_err, output, 16, index of first failing vector; N_VEC if none.

Behaviour:
- Reset (async, rst_n=0), all outputs registered:
  - stim_o=0, busy=0, done=0, pass=0, err_cnt=0, first_err=N_VEC, FSM=IDLE.
  - Vector index, LFSR and pipeline valid bits cleared.
- Reset asserted mid-run aborts immediately to these values; no done pulse.
- FSM:
  - IDLE: stim_o=0. Accepted start (start=1, busy=0) latches mode, clears err_cnt, pass and first_err, resets index k=0 and LFSR=16'hACE1, then enters RUN.
  - RUN: one vector per cycle, k=0..N_VEC-1; stim_o=pattern(k). After vector N_VEC-1 → DRAIN.
  - DRAIN: stim_o=0 for LAT cycles while outstanding vectors are compared; then → DONE.
  - DONE: done=1 for one cycle; pass <= (err_cnt==0); → IDLE.
- busy=1 in RUN, DRAIN and DONE. start while busy is ignored.
- Patterns (vector k):
  - walking-one: stim_o = 1<<(k mod N_I).
  - walking-zero: stim_o = ~(1<<(k mod N_I)).
  - LFSR: stim_o = LFSR[N_I-1:0]. The LFSR is a 16-bit Galois register, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advanced once per RUN cycle.
  - alternate: k even → all zeros, k odd → all ones.
- Checking:
  - The stim_o value, a valid bit and k enter a LAT-deep shift pipeline. The entry leaving the pipeline is compared with the inputs in that same cycle.
  - Expected obs_out[j] = stim[j].
  - Expected obs_io[i] = stim[i mod N_I], checked only where obs_oeb[i]=0.
  - A vector mismatches if any checked bit differs. Each mismatching vector adds 1 to err_cnt, saturating at 2^CNT_W-1.
  - The first mismatch of a run loads first_err with that vector's k.
- Total run length is N_VEC + LAT + 1 cycles from start acceptance to the done pulse.
- Inputs are assumed synchronous to clk; no synchronisers.

Optional Feature:
- Macro: TT_LBCHK_OEB_STRICT_EN.
- Defined: any obs_oeb bit =1 when a vector is checked also counts that vector as mismatching, so every bidirectional pad must be driving.
- Undefined: pads with obs_oeb=1 are don't-care and never contribute errors.

Test Plan:
- Perfect loopback (obs_out=stim delayed 2, obs_io likewise, oeb=0), mode 0, N_VEC=64 → done at start+67 cycles, pass=1, err_cnt=0, first_err=64.
- obs_out[3] stuck at 0, mode 0 → vectors 3, 13, 23, 33, 43, 53, 63 fail; err_cnt=7, first_err=3, pass=0.
- Without strict: obs_oeb=8'hF0, upper io bits forced wrong, mode 3 → pass=1. With TT_LBCHK_OEB_STRICT_EN → err_cnt=64.
- Mode 2: stim_o on RUN cycles 0 and 1 equals 10'h0E1 and the next Galois step's low 10 bits; bench LFSR model matches stim_o for all 64 vectors.
- start pulsed during RUN is ignored (single done pulse). rst_n low mid-RUN → all outputs return to reset values asynchronously; no done pulse.
- Loopback latency 3 with LAT=2 → every non-constant vector mismatches; err_cnt counts them and saturates correctly with CNT_W=4 (stays 15).
